// File: rtl/cache_mem_ctrl_pkg.sv
// Shared types and sizes for the cache backing-memory controller.
// MEM_INIT_EN adds an INIT state that fills mem[i]=i after reset.
package cache_mem_ctrl_pkg;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 5;
    localparam int DEPTH       = 32;
    localparam int CNT_W       = 4;
    localparam int MEM_LAT_DEF = 2;

`ifdef MEM_INIT_EN
    typedef enum logic [2:0] {IDLE, INIT, WB, FILL, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, WB, FILL, RESP} state_t;
`endif
endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Request/response bundle between cache (master) and controller (slave).
// MEM_INIT_EN does not change this interface.
interface cache_mem_ctrl_if;
    import cache_mem_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wb;
    logic              req_fill;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] fill_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              busy;

    modport master (
        output req_valid, req_wb, req_fill, wb_addr, wb_data, fill_addr,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_wb, req_fill, wb_addr, wb_data, fill_addr,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/cache_mem_store.sv
// Single-port 32x5 backing store, synchronous write, registered read.
// The read register doubles as resp_data, so it holds between reads.
module cache_mem_store
    import cache_mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Array write; contents survive reset, but no write lands at a reset edge
    always_ff @(posedge clk) begin
        if (reset_n && we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port, cleared by reset and held between reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/cache_mem_ctrl.sv
// Cache backing-memory controller: optional writeback, then optional fill.
// Define MEM_INIT_EN to add a 32-cycle INIT pass writing mem[i]=i.
module cache_mem_ctrl
    import cache_mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    cache_mem_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MEM_LAT - 1);

`ifdef MEM_INIT_EN
    localparam state_t RST_STATE = INIT;
    logic [ADDR_W-1:0] init_idx;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              accept;
    logic              fill_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Capture the whole request at the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            fill_q      <= bus.req_fill;
            wb_addr_q   <= bus.wb_addr;
            wb_data_q   <= bus.wb_data;
            fill_addr_q <= bus.fill_addr;
        end
    end

`ifdef MEM_INIT_EN
    // Walk every address once while in INIT
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_idx <= '0;
        end else if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
        end
    end
`endif

    // Next state, counter reload and store port control
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        addr    = fill_addr_q;
        wdata   = wb_data_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (bus.req_wb) begin
                        state_n = WB;
                        cnt_n   = RELOAD;
                    end else if (bus.req_fill) begin
                        state_n = FILL;
                        cnt_n   = RELOAD;
                    end
                end
            end
`ifdef MEM_INIT_EN
            INIT: begin
                we    = 1'b1;
                addr  = init_idx;
                wdata = init_idx;
                if (init_idx == ADDR_W'(DEPTH - 1)) begin
                    state_n = IDLE;
                end
            end
`endif
            WB: begin
                addr = wb_addr_q;
                if (cnt == '0) begin
                    we      = 1'b1;
                    state_n = fill_q ? FILL : RESP;
                    cnt_n   = fill_q ? RELOAD : '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            FILL: begin
                if (cnt == '0) begin
                    re      = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    cache_mem_store u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = rdata;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl with MEM_LAT=2.
// Works with or without MEM_INIT_EN; without it the store is preloaded.
module tb_cache_mem_ctrl;
    import cache_mem_ctrl_pkg::*;

    localparam int LAT  = 2;
    localparam int L1   = LAT + 1;
    localparam int L2   = 2 * LAT + 1;
`ifdef MEM_INIT_EN
    localparam int INIT_CYC = 32;
    localparam int RST_BUSY = 1;
`else
    localparam int INIT_CYC = 0;
    localparam int RST_BUSY = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    cache_mem_ctrl_if bus ();

    cache_mem_ctrl #(.MEM_LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       wb;
        logic       fill;
        logic [4:0] wa;
        logic [4:0] wd;
        logic [4:0] fa;
        logic [4:0] data;
        int         lat;
    } vec_t;

    typedef struct {
        logic       chk;
        logic [4:0] data;
        int         lat;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!bus.req_ready && t < 200) begin
            tick();
            t++;
        end
        check({name, " ready"}, int'(bus.req_ready), 1);
    endtask

    task automatic issue(input logic wb, input logic fill,
                         input logic [4:0] wa, input logic [4:0] wd,
                         input logic [4:0] fa, input logic [4:0] data,
                         input string name);
        exp_t e;
        wait_ready(name);
        bus.req_valid = 1'b1;
        bus.req_wb    = wb;
        bus.req_fill  = fill;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.fill_addr = fa;
        tick();
        bus.req_valid = 1'b0;
        e.chk  = fill;
        e.data = data;
        e.lat  = (wb && fill) ? L2 : L1;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_resp();
        exp_t e;
        int   k = 1;
        e = sb.pop_front();
        while (!bus.resp_valid && k < 50) begin
            tick();
            k++;
        end
        check({e.name, " latency"}, k, e.lat);
        if (e.chk) begin
            check({e.name, " data"}, int'(bus.resp_data), int'(e.data));
        end
        tick();
        check({e.name, " pulse"}, int'(bus.resp_valid), 0);
        if (e.chk) begin
            check({e.name, " hold"}, int'(bus.resp_data), int'(e.data));
        end
    endtask

    initial begin
        vec_t tbl[10];
        int   k;
        int   seen;

        tbl[0] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd7,  5'd7,  L1};
        tbl[1] = '{1'b1, 1'b0, 5'd3,  5'd21, 5'd0,  5'd0,  L1};
        tbl[2] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd3,  5'd21, L1};
        tbl[3] = '{1'b1, 1'b1, 5'd4,  5'd9,  5'd10, 5'd10, L2};
        tbl[4] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd4,  5'd9,  L1};
        tbl[5] = '{1'b1, 1'b1, 5'd12, 5'd30, 5'd12, 5'd30, L2};
        tbl[6] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd31, 5'd31, L1};
        tbl[7] = '{1'b1, 1'b1, 5'd31, 5'd0,  5'd31, 5'd0,  L2};
        tbl[8] = '{1'b1, 1'b0, 5'd0,  5'd31, 5'd0,  5'd0,  L1};
        tbl[9] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd31, L1};

        bus.req_valid = 1'b0;
        bus.req_wb    = 1'b0;
        bus.req_fill  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.fill_addr = '0;

        reset_n = 1'b0;
        repeat (3) tick();
        check("rst busy", int'(bus.busy), RST_BUSY);
        check("rst ready", int'(bus.req_ready), 1 - RST_BUSY);
        check("rst resp_valid", int'(bus.resp_valid), 0);
        check("rst resp_data", int'(bus.resp_data), 0);

        reset_n = 1'b1;
        k = 0;
        while (bus.busy && k < 100) begin
            k++;
            tick();
        end
        check("init cycles", k, INIT_CYC);
        check("init ready", int'(bus.req_ready), 1);

`ifndef MEM_INIT_EN
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 1'b0, 5'(i), 5'(i), 5'd0, 5'd0, "preload");
            wait_resp();
        end
`endif

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].wb, tbl[i].fill, tbl[i].wa, tbl[i].wd,
                  tbl[i].fa, tbl[i].data, $sformatf("vec%0d", i));
            wait_resp();
        end

        wait_ready("hold");
        bus.req_valid = 1'b1;
        bus.req_wb    = 1'b0;
        bus.req_fill  = 1'b1;
        bus.fill_addr = 5'd7;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.resp_valid) seen++;
            tick();
        end
        bus.req_valid = 1'b0;
        check("hold resp count", seen, 5);
        check("hold data", int'(bus.resp_data), 7);
        check("hold idle", int'(bus.busy), 0);

        wait_ready("noop");
        bus.req_valid = 1'b1;
        bus.req_wb    = 1'b0;
        bus.req_fill  = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        check("noop busy", int'(bus.busy), 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid) seen++;
            tick();
        end
        check("noop resp count", seen, 0);

        wait_ready("abort");
        bus.req_valid = 1'b1;
        bus.req_wb    = 1'b1;
        bus.req_fill  = 1'b0;
        bus.wb_addr   = 5'd5;
        bus.wb_data   = 5'd17;
        tick();
        bus.req_valid = 1'b0;
        check("abort in wb", int'(bus.busy), 1);
        reset_n = 1'b0;
        tick();
        check("abort resp_data", int'(bus.resp_data), 0);
        check("abort busy", int'(bus.busy), RST_BUSY);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.resp_valid) seen++;
            tick();
        end
        check("abort resp count", seen, 0);

        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 5'd5, "after abort 5");
        wait_resp();
`ifdef MEM_INIT_EN
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 5'd3, "reinit 3");
`else
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 5'd21, "kept 3");
`endif
        wait_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_ctrl.md
CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, giving backing-memory access latency in cycles per access (legal range 1..15).
REQ-002 The block SHALL have one clock and one reset: clock is the sole clock, and reset is synchronous and active-low. The ports are listed in REQ-003 and REQ-004.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  cache presents a request.
REQ-006 req_ready  out  1  controller can accept a request this cycle.
REQ-007 req_wb  in  1  request includes a dirty-block writeback.
REQ-008 req_fill  in  1  request includes a block fill.
REQ-009 wb_addr  in  5  writeback address.
REQ-010 wb_data  in  5  writeback block.
REQ-011 fill_addr  in  5  fill address.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_data  out  5  fill block, valid when resp_valid=1 and the request had req_fill=1.
REQ-014 busy  out  1  FSM not in IDLE.

Function
REQ-015 The block SHALL contain a 32x5 backing store indexed by 5-bit address.
REQ-016 FSM states SHALL be IDLE, INIT, WB, FILL and RESP; req_ready=1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, and all request inputs SHALL be latched at that edge.
REQ-018 On acceptance, the FSM SHALL go IDLE->WB if req_wb=1, else IDLE->FILL if req_fill=1, else stay in IDLE with no response.
REQ-019 WB and FILL SHALL each last exactly MEM_LAT cycles, timed by a 4-bit down-counter reloaded on state entry.
REQ-020 The store SHALL be written with the latched wb_data at the last WB cycle; then the FSM goes to FILL if req_fill was latched, else to RESP.
REQ-021 The store SHALL be read at the latched fill_addr in the last FILL cycle; resp_data is registered, then the FSM goes to RESP.
REQ-022 RESP SHALL last one cycle with resp_valid=1, then return to IDLE.
REQ-023 Latency from the accept edge to the resp_valid cycle SHALL be: MEM_LAT+1 for fill-only or wb-only; 2*MEM_LAT+1 for wb+fill.
REQ-024 On wb+fill with wb_addr==fill_addr, resp_data SHALL equal the newly written wb_data, because the write precedes the read.
REQ-025 resp_data SHALL hold its last value when resp_valid=0.

Reset
REQ-026 While reset_n=0 at an edge: state becomes INIT (macro defined) or IDLE (macro undefined); counter=0; resp_valid=0; resp_data=0; busy per state.
REQ-027 Reset mid-operation SHALL abort the request with no response; a WB write not yet reached SHALL NOT occur.

Configuration
REQ-028 With MEM_INIT_EN defined, after reset the FSM SHALL spend 32 cycles in INIT writing mem[i]=i for i=0..31 (busy=1, req_ready=0), then enter IDLE.
REQ-029 Without MEM_INIT_EN, there SHALL be no INIT state, reset SHALL go directly to IDLE, and store contents SHALL be unaffected by reset.

Structure
REQ-030 A shared package SHALL hold ADDR_W=5, DATA_W=5, the FSM state enum and the MEM_LAT default.
REQ-031 The store SHALL be a sub-module cache_mem_store: a single-port 32x5 array with synchronous write and registered read.

Verification (MEM_INIT_EN defined, MEM_LAT=2)
REQ-032 Release reset -> busy=1 for 32 cycles, then req_ready=1; a fill of address 7 -> resp_data=7 in the 3rd cycle after accept.
REQ-033 wb-only addr 3 data 21, then fill addr 3 -> the first resp_valid has 3-cycle latency; the fill returns 21.
REQ-034 wb+fill, wb_addr=4 data 9, fill_addr=10 -> resp_valid in the 5th cycle after accept, resp_data=10; a later fill of 4 returns 9.
REQ-035 wb+fill with both addresses 12, data 30 -> resp_data=30.
REQ-036 req_valid held high during busy -> no second accept until IDLE; req with wb=fill=0 -> no resp_valid.
REQ-037 Assert reset_n=0 during the first WB cycle (wb addr 5, data 17) -> no resp_valid; after INIT, a fill of 5 returns 5.
